pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised next-PC generator for the fetch stage, succeeding the plain PC register. It holds the fetch PC, advances it sequentially, and applies stalls, execute-stage redirects and decode-stage jumps in a fixed priority. It also maintains a small circular return-address stack (RAS), so that `jr $ra`-style returns are predicted in decode instead of waiting for execute. It sits between the instruction memory address port and the decode and execute stages.

## Interface
Parameters:
- `WIDTH`, 32: PC width in bits.
- `RESET_PC`, 32'h0: PC value loaded on reset; `WIDTH` bits.
- `INSN_BYTES`, 4: sequential increment.
- `RAS_DEPTH`, 4: RAS entries; must be a power of two, ≥2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold the PC; decode-stage requests are ignored.
- `redirect_valid`  in  1  execute-stage redirect (mispredict or exception).
- `redirect_pc`  in  `WIDTH`  target for `redirect_valid`.
- `dec_jump`  in  1  decode-stage unconditional jump or call.
- `dec_target`  in  `WIDTH`  jump target; also the fallback target for returns.
- `dec_call`  in  1  push `dec_link` onto the RAS; qualified by `dec_jump`.
- `dec_link`  in  `WIDTH`  return address to push.
- `dec_ret`  in  1  return; target is the RAS top; qualified by `dec_jump`.
- `pc`  out  `WIDTH`  current fetch PC, registered.
- `pc_plus`  out  `WIDTH`  `pc + INSN_BYTES`, combinational.
- `ras_top`  out  `WIDTH`  current RAS top entry; 0 when empty.
- `ras_count`  out  `$clog2(RAS_DEPTH)+1`  number of valid entries.
- `ras_empty`, `ras_full`  out  1  RAS status flags.

## Operation
Next-PC priority, highest first:
1. `rst`: `pc` = `RESET_PC`, RAS cleared (count 0, pointer 0).
2. `redirect_valid`: `pc` = `redirect_pc`. Applies even when `stall`=1. Any decode request in the same cycle is squashed and the RAS is not touched.
3. `stall`: `pc` holds and the RAS holds.
4. `dec_jump`:
   - `dec_ret`=1 and RAS non-empty: `pc` = `ras_top`, then pop.
   - `dec_ret`=1 and RAS empty: `pc` = `dec_target`; no pop; count stays 0.
   - Otherwise: `pc` = `dec_target`.
   - `dec_call`=1 pushes `dec_link`.
5. Otherwise: `pc` = `pc_plus`.

RAS rules:
- Circular buffer of `RAS_DEPTH` entries plus a top pointer.
- Push when full overwrites the oldest entry (pointer wraps). Count saturates at `RAS_DEPTH`; `ras_full` stays 1.
- `dec_call` and `dec_ret` together (call through a return): pop then push, so the top is replaced and count is unchanged. If the RAS is empty, the PC takes `dec_target` and only the push happens.
- `dec_call`/`dec_ret` without `dec_jump` have no effect.

Arithmetic:
- All PC arithmetic is modulo 2^`WIDTH`; `pc_plus` wraps silently.
- There is no alignment check.

## Timing
- Reset: `pc`=`RESET_PC`, `ras_count`=0, `ras_empty`=1, `ras_full`=0, `ras_top`=0. These values are visible after the first rising edge with `rst`=1.
- All requests are sampled at a rising edge; the new `pc` and RAS state are visible immediately after that edge (latency 1).
- `pc_plus` and `ras_top` follow the registered state combinationally, with zero latency.
- `rst` asserted mid-stream discards in-flight pushes and pops of that cycle.
- There is no handshake: requests are single-cycle pulses; a level held across N unstalled cycles acts N times.

## Test plan
- Reset then free run, `RESET_PC`=0, `INSN_BYTES`=4 -> `pc` 0, 4, 8, 12 on successive edges.
- `stall`=1 for 3 cycles at `pc`=8 -> `pc` holds 8; `redirect_valid`=1 with `redirect_pc`=0x100 during the stall -> `pc`=0x100 next edge.
- `dec_jump`+`dec_call`, `dec_target`=0x400, `dec_link`=0x10 -> `pc`=0x400, `ras_top`=0x10, `ras_count`=1. Later `dec_jump`+`dec_ret` -> `pc`=0x10, `ras_empty`=1.
- With `RAS_DEPTH`=4, push 0x10, 0x20, 0x30, 0x40, 0x50 -> `ras_full`=1, count 4. Five returns -> targets 0x50, 0x40, 0x30, 0x20, then `dec_target` on the fifth.
- `redirect_valid` and `dec_jump`+`dec_call` in the same cycle -> `pc`=`redirect_pc`, RAS unchanged. Simultaneous `dec_call`+`dec_ret` with top 0x20 and `dec_link` 0x80 -> `pc`=0x20, `ras_top`=0x80, count unchanged.
- `pc`=32'hFFFFFFFC, no requests -> `pc` wraps to 0.

Source files
------------

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen -- fetch-stage next-PC generator with a circular return-address stack.
//
// Holds the fetch PC and selects the next one. Priority, highest first:
// reset, execute-stage redirect, stall, decode-stage jump/call/return,
// sequential advance.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   stall               hold PC and RAS; decode requests ignored
//   redirect_valid/_pc  execute-stage redirect; wins over stall and decode
//   dec_jump/_target    decode-stage jump; target is also the return fallback
//   dec_call/_link      push return address (qualified by dec_jump)
//   dec_ret             return to RAS top (qualified by dec_jump)
//   pc                  registered fetch PC
//   pc_plus             pc + INSN_BYTES, combinational, wraps
//   ras_top             current RAS top entry, 0 when empty
//   ras_count           number of valid RAS entries (saturates at RAS_DEPTH)
//   ras_empty/ras_full  RAS status flags
// -----------------------------------------------------------------------------
module pc_gen #(
    parameter int unsigned       WIDTH      = 32,
    parameter logic [WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned       INSN_BYTES = 4,
    parameter int unsigned       RAS_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          redirect_valid,
    input  logic [WIDTH-1:0]              redirect_pc,
    input  logic                          dec_jump,
    input  logic [WIDTH-1:0]              dec_target,
    input  logic                          dec_call,
    input  logic [WIDTH-1:0]              dec_link,
    input  logic                          dec_ret,
    output logic [WIDTH-1:0]              pc,
    output logic [WIDTH-1:0]              pc_plus,
    output logic [WIDTH-1:0]              ras_top,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          ras_empty,
    output logic                          ras_full
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_gen: RAS_DEPTH must be a power of two and at least 2");
    end

    // Stack operation selected for this cycle.
    typedef enum logic [1:0] {
        RAS_HOLD,
        RAS_PUSH,
        RAS_POP,
        RAS_SWAP   // call through a return: pop then push == overwrite top
    } ras_op_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
    logic [CNT_W-1:0] ras_count_q, ras_count_d;
    logic [PTR_W-1:0] ptr_inc, ptr_dec;
    ras_op_e          ras_op;

    // Outputs follow registered state.
    assign pc        = pc_q;
    assign pc_plus   = pc_q + WIDTH'(INSN_BYTES);
    assign ras_count = ras_count_q;
    assign ras_empty = (ras_count_q == '0);
    assign ras_full  = (ras_count_q == CNT_W'(RAS_DEPTH));
    assign ras_top   = ras_empty ? '0 : ras_mem_q[ras_ptr_q];

    // The pointer always addresses the top entry; the buffer is a power of
    // two, so natural wrap of the pointer gives the circular behaviour and a
    // push when full overwrites the oldest entry.
    assign ptr_inc = ras_ptr_q + PTR_W'(1);
    assign ptr_dec = ras_ptr_q - PTR_W'(1);

    // Next-PC selection and RAS operation decode.
    always_comb begin
        pc_d   = pc_plus;
        ras_op = RAS_HOLD;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (dec_jump) begin
            if (dec_ret && !ras_empty) begin
                pc_d   = ras_top;
                ras_op = dec_call ? RAS_SWAP : RAS_POP;
            end else begin
                // Plain jump, call, or return with nothing predicted.
                pc_d = dec_target;
                if (dec_call) begin
                    ras_op = RAS_PUSH;
                end
            end
        end
    end

    // RAS next state.
    always_comb begin
        ras_mem_d   = ras_mem_q;
        ras_ptr_d   = ras_ptr_q;
        ras_count_d = ras_count_q;
        unique case (ras_op)
            RAS_PUSH: begin
                ras_ptr_d          = ptr_inc;
                ras_mem_d[ptr_inc] = dec_link;
                if (!ras_full) begin
                    ras_count_d = ras_count_q + CNT_W'(1);
                end
            end
            RAS_POP: begin
                ras_ptr_d   = ptr_dec;
                ras_count_d = ras_count_q - CNT_W'(1);
            end
            RAS_SWAP: begin
                ras_mem_d[ras_ptr_q] = dec_link;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            ras_ptr_q   <= '0;
            ras_count_q <= '0;
            ras_mem_q   <= '{default: '0};
        end else begin
            pc_q        <= pc_d;
            ras_ptr_q   <= ras_ptr_d;
            ras_count_q <= ras_count_d;
            ras_mem_q   <= ras_mem_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen (WIDTH 32, RESET_PC 0,
// INSN_BYTES 4, RAS_DEPTH 4). A queue-based reference model tracks the PC and
// return stack; every negedge the DUT outputs are compared to it. Directed
// scenarios also check hand-computed literals against both DUT and model.
// -----------------------------------------------------------------------------
module tb_pc_gen;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_jump = 1'b0;
    logic [31:0] dec_target = '0;
    logic        dec_call = 1'b0;
    logic [31:0] dec_link = '0;
    logic        dec_ret = 1'b0;
    logic [31:0] pc, pc_plus, ras_top;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full;

    pc_gen #(
        .WIDTH(32),
        .RESET_PC(32'h0),
        .INSN_BYTES(4),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .dec_jump(dec_jump),
        .dec_target(dec_target),
        .dec_call(dec_call),
        .dec_link(dec_link),
        .dec_ret(dec_ret),
        .pc(pc),
        .pc_plus(pc_plus),
        .ras_top(ras_top),
        .ras_count(ras_count),
        .ras_empty(ras_empty),
        .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];   // back = top of stack
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 32'h0;
            m_ras.delete();
            m_valid = 1'b1;
        end else if (redirect_valid) begin
            m_pc = redirect_pc;
        end else if (stall) begin
            // hold everything
        end else if (dec_jump) begin
            if (dec_ret && m_ras.size() > 0) begin
                m_pc = m_ras[$];
                void'(m_ras.pop_back());
            end else begin
                m_pc = dec_target;
            end
            if (dec_call) begin
                m_ras.push_back(dec_link);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
        end else begin
            m_pc = m_pc + 32'd4;
        end
    end

    function automatic logic [31:0] m_top();
        return (m_ras.size() > 0) ? m_ras[$] : 32'h0;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            chk("pc", pc, m_pc);
            chk("pc_plus", pc_plus, m_pc + 32'd4);
            chk("ras_top", ras_top, m_top());
            chk("ras_count", 32'(ras_count), 32'(m_ras.size()));
            chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
            chk("ras_full", 32'(ras_full), 32'(m_ras.size() == DEPTH));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic st, input logic rv, input logic [31:0] rpc,
                         input logic j, input logic c, input logic rt,
                         input logic [31:0] tgt, input logic [31:0] lnk);
        @(negedge clk);
        rst = r; stall = st; redirect_valid = rv; redirect_pc = rpc;
        dec_jump = j; dec_call = c; dec_ret = rt; dec_target = tgt; dec_link = lnk;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic lit_pc(input string name, input logic [31:0] exp);
        chk({name, "_dut_pc"}, pc, exp);
        chk({name, "_model_pc"}, m_pc, exp);
    endtask

    task automatic lit_ras(input string name, input logic [31:0] top, input int cnt,
                           input logic emp, input logic ful);
        chk({name, "_ras_top"}, ras_top, top);
        chk({name, "_ras_count"}, 32'(ras_count), 32'(cnt));
        chk({name, "_model_count"}, 32'(m_ras.size()), 32'(cnt));
        chk({name, "_ras_empty"}, 32'(ras_empty), 32'(emp));
        chk({name, "_ras_full"}, 32'(ras_full), 32'(ful));
    endtask

    initial begin
        logic [31:0] exp_ret [5];
        exp_ret = '{32'h50, 32'h40, 32'h30, 32'h20, 32'h300};

        // Reset and free run.
        drive(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        lit_pc("reset", 32'h0);
        lit_ras("reset", 32'h0, 0, 1'b1, 1'b0);
        idle(); lit_pc("run1", 32'h4);
        idle(); lit_pc("run2", 32'h8);

        // Stall holds; redirect wins over stall.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 32'h0, 1, 1, 0, 32'h700, 32'h77);
            lit_pc("stall", 32'h8);
            lit_ras("stall", 32'h0, 0, 1'b1, 1'b0);
        end
        drive(0, 1, 1, 32'h100, 0, 0, 0, 32'h0, 32'h0);
        lit_pc("stall_redirect", 32'h100);

        // Call then return.
        drive(0, 0, 0, 32'h0, 1, 1, 0, 32'h400, 32'h10);
        lit_pc("call", 32'h400);
        lit_ras("call", 32'h10, 1, 1'b0, 1'b0);
        drive(0, 0, 0, 32'h0, 1, 0, 1, 32'h999, 32'h0);
        lit_pc("ret", 32'h10);
        lit_ras("ret", 32'h0, 0, 1'b1, 1'b0);

        // call/ret without dec_jump do nothing.
        drive(0, 0, 0, 32'h0, 0, 1, 1, 32'h888, 32'h44);
        lit_pc("unqualified", 32'h14);
        lit_ras("unqualified", 32'h0, 0, 1'b1, 1'b0);

        // Overflow: five pushes into four entries.
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 0, 32'h0, 1, 1, 0, 32'h200, 32'(i * 16));
        end
        lit_ras("overflow", 32'h50, 4, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 32'h0, 1, 0, 1, 32'h300, 32'h0);
            lit_pc($sformatf("pop%0d", i), exp_ret[i]);
        end
        lit_ras("drained", 32'h0, 0, 1'b1, 1'b0);

        // Redirect squashes a same-cycle call.
        drive(0, 0, 0, 32'h0, 1, 1, 0, 32'h600, 32'h20);
        drive(0, 0, 1, 32'h500, 1, 1, 0, 32'h640, 32'h60);
        lit_pc("redirect_squash", 32'h500);
        lit_ras("redirect_squash", 32'h20, 1, 1'b0, 1'b0);

        // Call through a return replaces the top.
        drive(0, 0, 0, 32'h0, 1, 1, 1, 32'h900, 32'h80);
        lit_pc("swap", 32'h20);
        lit_ras("swap", 32'h80, 1, 1'b0, 1'b0);

        // Call through a return on an empty stack: target taken, push only.
        drive(0, 0, 0, 32'h0, 1, 0, 1, 32'h0, 32'h0);
        drive(0, 0, 0, 32'h0, 1, 1, 1, 32'h940, 32'h90);
        lit_pc("swap_empty", 32'h940);
        lit_ras("swap_empty", 32'h90, 1, 1'b0, 1'b0);

        // PC wraps.
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0, 32'h0);
        chk("wrap_pc_plus", pc_plus, 32'h0);
        idle(); lit_pc("wrap", 32'h0);

        // Reset discards a same-cycle push.
        drive(1, 0, 0, 32'h0, 1, 1, 0, 32'h400, 32'h44);
        lit_pc("reset_mid", 32'h0);
        lit_ras("reset_mid", 32'h0, 0, 1'b1, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] rpc, tgt, lnk;
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
            tgt = $urandom & 32'h0000_FFFC;
            lnk = $urandom;
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0), rpc,
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 1) == 0),
                  tgt, lnk);
        end

        idle();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
